// File: rtl/clk_div_bank_pkg.sv
// Shared types and width helpers for the divided-clock bank.
package clk_div_bank_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 8;

  typedef logic [DIV_WIDTH_DEF-1:0] div_t;

  // Width able to hold 0..lock_cycles inclusive.
  function automatic int unsigned lock_cnt_w(input int unsigned lock_cycles);
    return unsigned'($clog2(lock_cycles + 1));
  endfunction

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor-update request channel of the divided-clock bank.
interface clk_div_bank_if
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
);
  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [CH_W-1:0]      cfg_ch_i;
  logic [DIV_WIDTH-1:0] cfg_div_i;

  modport master (output cfg_valid_i, output cfg_ch_i, output cfg_div_i, input cfg_ready_o);
  modport slave  (input cfg_valid_i, input cfg_ch_i, input cfg_div_i, output cfg_ready_o);

endinterface

// File: rtl/clk_div_ch.sv
// One divided-clock channel: shadowed divisor applied on a period boundary,
// flop-driven clock output and a saturating lock detector.
module clk_div_ch
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 wr_i,
  input  logic [DIV_WIDTH-1:0] wdiv_i,
  output logic                 clk_o,
  output logic                 locked_o,
  output logic                 busy_o
);

  localparam int unsigned     LW       = lock_cnt_w(LOCK_CYCLES);
  localparam logic [LW-1:0]   LOCK_MAX = LW'(LOCK_CYCLES);

  logic [DIV_WIDTH-1:0] act_q, act_d;
  logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [LW-1:0]        per_q, per_d;
  logic                 busy_q, busy_d;
  logic                 clk_q, clk_d;
  logic                 locked_q, locked_d;

  logic [DIV_WIDTH-1:0] new_eff;
  logic [DIV_WIDTH:0]   half;
  logic                 wrap;
  logic                 apply;

  always_comb begin
    act_d    = act_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    busy_d   = busy_q;

    new_eff = (shadow_q == DIV_WIDTH'(1)) ? DIV_WIDTH'(2) : shadow_q;
    wrap    = (act_q != '0) && (cnt_q == act_q - DIV_WIDTH'(1));
    // A disabled channel has no boundary to wait for.
    apply   = busy_q && ((act_q == '0) || wrap);

    if (wr_i) begin
      shadow_d = wdiv_i;
      busy_d   = 1'b1;
    end

    if (act_q != '0) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    if (wrap && (per_q != LOCK_MAX)) begin
      per_d = per_q + LW'(1);
    end

    if (apply) begin
      busy_d = 1'b0;
      act_d  = new_eff;
      cnt_d  = '0;
      if (new_eff != act_q) begin
        per_d = '0;
      end
    end

    if (act_d == '0) begin
      cnt_d = '0;
      per_d = '0;
    end

    // Output flop is computed from next-state so clk_o tracks cnt with no skew.
    half     = ({1'b0, act_d} + (DIV_WIDTH + 1)'(1)) >> 1;
    clk_d    = ({1'b0, cnt_d} < half);
    locked_d = (act_d != '0) && (per_d == LOCK_MAX);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      act_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      per_q    <= '0;
      busy_q   <= 1'b0;
      clk_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      busy_q   <= busy_d;
      clk_q    <= clk_d;
      locked_q <= locked_d;
    end
  end

  assign clk_o    = clk_q;
  assign locked_o = locked_q;
  assign busy_o   = busy_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers behind a single
// valid/ready divisor-update port.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] locked_o,
  output logic [NUM_CH-1:0] busy_o
);

  logic [NUM_CH-1:0] wr;

  // Out-of-range indices match no channel: ready stays high, request dropped.
  always_comb begin
    cfg.cfg_ready_o = 1'b1;
    wr              = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cfg.cfg_ch_i) == i) begin
        cfg.cfg_ready_o = ~busy_o[i];
        wr[i]           = cfg.cfg_valid_i & ~busy_o[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .DIV_WIDTH   (DIV_WIDTH),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .wr_i     (wr[g]),
      .wdiv_i   (cfg.cfg_div_i),
      .clk_o    (clk_o[g]),
      .locked_o (locked_o[g]),
      .busy_o   (busy_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: per-divisor waveform table plus
// hand-built lock, retiming, back-pressure and reset sequences.
module tb_clk_div_bank;
  import clk_div_bank_pkg::*;

  typedef enum logic [1:0] {SIG_CLK, SIG_LOCK, SIG_BUSY, SIG_RDY} sig_e;

  typedef struct {
    int unsigned due;
    sig_e        sig;
    int unsigned ch;
    int          val;
    string       tag;
  } exp_t;

  typedef struct {
    int unsigned ch;
    div_t        dv;
    int unsigned len;
    logic [15:0] pat;   // waveform MSB-first, len bits
  } vec_t;

  logic       clk;
  logic       arst_ni;
  logic [3:0] clk_o;
  logic [3:0] locked_o;
  logic [3:0] busy_o;

  clk_div_bank_if #(.NUM_CH(4), .DIV_WIDTH(8)) cfg_if ();

  clk_div_bank #(
    .NUM_CH      (4),
    .DIV_WIDTH   (8),
    .LOCK_CYCLES (16)
  ) dut (
    .clk_i    (clk),
    .arst_ni  (arst_ni),
    .cfg      (cfg_if),
    .clk_o    (clk_o),
    .locked_o (locked_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  exp_t        sbq[$];

  function automatic void chk(input string tag, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp_v, cyc);
  endfunction

  function automatic int act_of(input sig_e s, input int unsigned ch);
    case (s)
      SIG_CLK:  return int'(clk_o[ch]);
      SIG_LOCK: return int'(locked_o[ch]);
      SIG_BUSY: return int'(busy_o[ch]);
      default:  return int'(cfg_if.cfg_ready_o);
    endcase
  endfunction

  function automatic void push(input int unsigned due, input sig_e s, input int unsigned ch,
                               input int v, input string tag);
    exp_t e;
    int unsigned k;
    e.due = due; e.sig = s; e.ch = ch; e.val = v; e.tag = tag;
    k = sbq.size();
    while (k > 0 && sbq[k-1].due > due) k--;
    sbq.insert(k, e);
  endfunction

  function automatic void check_due();
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due != cyc) chk({e.tag, "_missed"}, int'(cyc), int'(e.due));
      else              chk(e.tag, act_of(e.sig, e.ch), e.val);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic drain();
    while (sbq.size() > 0) tick();
  endtask

  task automatic do_reset();
    cfg_if.cfg_valid_i = 1'b0;
    arst_ni = 1'b0;
    tick();
    tick();
    arst_ni = 1'b1;
  endtask

  // Presents a request and waits for ready; acc_o is the edge that will accept it.
  task automatic wait_ready(input int unsigned ch, input int unsigned dv, output int unsigned acc_o);
    int unsigned n = 0;
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_ch_i    = 2'(ch);
    cfg_if.cfg_div_i   = 8'(dv);
    while (!cfg_if.cfg_ready_o && n < 300) begin
      tick();
      n++;
    end
    if (!cfg_if.cfg_ready_o) chk("wr_timeout", 0, 1);
    acc_o = cyc + 1;
  endtask

  task automatic accept();
    tick();
    cfg_if.cfg_valid_i = 1'b0;
  endtask

  vec_t        vec[7];
  int unsigned acc, acc2, p;

  initial begin
    vec[0] = '{0, 8'd4, 4, 16'b1100};
    vec[1] = '{1, 8'd3, 3, 16'b110};
    vec[2] = '{2, 8'd1, 2, 16'b10};
    vec[3] = '{3, 8'd5, 5, 16'b11100};
    vec[4] = '{0, 8'd6, 6, 16'b111000};
    vec[5] = '{1, 8'd2, 2, 16'b10};
    vec[6] = '{2, 8'd7, 7, 16'b1111000};

    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_ch_i    = '0;
    cfg_if.cfg_div_i   = '0;
    arst_ni = 1'b1;
    #2 arst_ni = 1'b0;
    #1;
    chk("rst_clk", int'(clk_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ready", int'(cfg_if.cfg_ready_o), 1);
    tick();
    arst_ni = 1'b1;

    // Waveform per divisor, two full periods after the apply edge.
    for (int r = 0; r < 7; r++) begin
      do_reset();
      wait_ready(vec[r].ch, int'(vec[r].dv), acc);
      push(acc,     SIG_BUSY, vec[r].ch, 1, "tbl_busy_set");
      push(acc,     SIG_CLK,  vec[r].ch, 0, "tbl_clk_idle");
      push(acc + 1, SIG_BUSY, vec[r].ch, 0, "tbl_busy_clr");
      for (int unsigned k = 0; k < 2 * vec[r].len; k++) begin
        push(acc + 1 + k, SIG_CLK, vec[r].ch,
             int'(vec[r].pat[vec[r].len - 1 - (k % vec[r].len)]), "tbl_clk");
      end
      accept();
      drain();
    end

    // ch0 div=4: lock after 16 periods.
    do_reset();
    wait_ready(0, 4, acc);
    p = acc + 1;
    push(p + 63, SIG_LOCK, 0, 0, "lock4_early");
    push(p + 64, SIG_LOCK, 0, 1, "lock4_set");
    push(p + 70, SIG_LOCK, 0, 1, "lock4_hold");
    accept();
    drain();

    // ch1 div=3 locked, retimed to 5 mid-period.
    do_reset();
    wait_ready(1, 3, acc);
    p = acc + 1;
    push(p + 47, SIG_LOCK, 1, 0, "lock3_early");
    push(p + 48, SIG_LOCK, 1, 1, "lock3_set");
    accept();
    wait_until(p + 52);
    wait_ready(1, 5, acc2);
    chk("r35_accept_cycle", int'(acc2), int'(p + 53));
    push(acc2,     SIG_CLK,  1, 0, "r35_old_tail");
    push(acc2,     SIG_BUSY, 1, 1, "r35_busy");
    push(acc2,     SIG_LOCK, 1, 1, "r35_lock_held");
    push(acc2,     SIG_RDY,  1, 0, "r35_ready_low");
    push(acc2 + 1, SIG_LOCK, 1, 0, "r35_lock_drop");
    push(acc2 + 1, SIG_BUSY, 1, 0, "r35_busy_clr");
    push(acc2 + 1, SIG_RDY,  1, 1, "r35_ready_high");
    for (int unsigned k = 0; k < 10; k++)
      push(acc2 + 1 + k, SIG_CLK, 1, ((k % 5) < 3) ? 1 : 0, "r35_clk");
    accept();
    drain();

    // ch2 div=1 locked, then disabled.
    do_reset();
    wait_ready(2, 1, acc);
    p = acc + 1;
    push(p + 31, SIG_LOCK, 2, 0, "lock2_early");
    push(p + 32, SIG_LOCK, 2, 1, "lock2_set");
    accept();
    wait_until(p + 40);
    wait_ready(2, 0, acc2);
    push(acc2,     SIG_LOCK, 2, 1, "dis_lock_held");
    push(acc2,     SIG_BUSY, 2, 1, "dis_busy");
    push(acc2,     SIG_CLK,  2, 0, "dis_low_phase");
    push(acc2 + 1, SIG_LOCK, 2, 0, "dis_lock_drop");
    push(acc2 + 1, SIG_BUSY, 2, 0, "dis_busy_clr");
    for (int unsigned k = 1; k <= 4; k++) push(acc2 + k, SIG_CLK, 2, 0, "dis_clk_low");
    accept();
    drain();

    // ch0: div=8 pending at div=4, second write held until the boundary.
    do_reset();
    wait_ready(0, 4, acc);
    p = acc + 1;
    accept();
    wait_until(p + 4);
    wait_ready(0, 8, acc);
    push(acc, SIG_BUSY, 0, 1, "b2b_busy");
    accept();
    push(acc + 1, SIG_RDY,  0, 0, "b2b_hold1");
    push(acc + 2, SIG_RDY,  0, 0, "b2b_hold2");
    push(acc + 3, SIG_RDY,  0, 1, "b2b_release");
    push(acc + 3, SIG_BUSY, 0, 0, "b2b_busy_clr");
    for (int unsigned k = 0; k < 8; k++)
      push(acc + 3 + k, SIG_CLK, 0, (k < 4) ? 1 : 0, "b2b_clk8");
    wait_ready(0, 2, acc2);
    chk("b2b_accept_cycle", int'(acc2), int'(acc + 4));
    push(acc2,     SIG_BUSY, 0, 1, "b2b_busy2");
    push(acc + 11, SIG_BUSY, 0, 0, "b2b_busy2_clr");
    for (int unsigned k = 0; k < 4; k++)
      push(acc + 11 + k, SIG_CLK, 0, ((k % 2) == 0) ? 1 : 0, "b2b_clk2");
    accept();
    drain();

    // ch3 div=6 locked; same-divisor rewrite keeps lock and phase.
    do_reset();
    wait_ready(3, 6, acc);
    p = acc + 1;
    push(p + 95, SIG_LOCK, 3, 0, "lock6_early");
    push(p + 96, SIG_LOCK, 3, 1, "lock6_set");
    for (int unsigned c = p + 100; c < p + 116; c++) begin
      push(c, SIG_LOCK, 3, 1, "same_lock");
      push(c, SIG_CLK,  3, (((c - p) % 6) < 3) ? 1 : 0, "same_phase");
    end
    accept();
    wait_until(p + 100);
    wait_ready(3, 6, acc2);
    push(acc2,     SIG_BUSY, 3, 1, "same_busy");
    push(acc2 + 1, SIG_BUSY, 3, 0, "same_busy_clr");
    accept();
    drain();

    // Reset mid-period with an update pending.
    do_reset();
    wait_ready(0, 8, acc);
    p = acc + 1;
    accept();
    wait_until(p + 2);
    wait_ready(0, 3, acc);
    accept();
    chk("pre_rst_busy", int'(busy_o[0]), 1);
    chk("pre_rst_clk", int'(clk_o[0]), 1);
    #2 arst_ni = 1'b0;
    #1;
    chk("arst_clk", int'(clk_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_locked", int'(locked_o), 0);
    chk("arst_ready", int'(cfg_if.cfg_ready_o), 1);
    tick();
    tick();
    arst_ni = 1'b1;
    for (int unsigned k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_clk", int'(clk_o), 0);
      chk("post_rst_busy", int'(busy_o), 0);
    end
    chk("post_rst_locked", int'(locked_o), 0);
    for (int unsigned c = 0; c < 4; c++) begin
      cfg_if.cfg_ch_i = 2'(c);
      #1 chk("post_rst_ready", int'(cfg_if.cfg_ready_o), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
